// File: rtl/stream_upsize_ctrl_if.sv
// Handshake bundle between the upsizer controller, its narrow source and wide sink.
// master = controller view, slave = surrounding datapath / environment view.
interface stream_upsize_ctrl_if #(
   parameter int unsigned T_DATA_RATIO = 2
);
   logic                    s_valid_i;
   logic                    s_last_i;
   logic                    s_ready_o;
   logic [T_DATA_RATIO-1:0] lane_we_o;
   logic                    m_valid_o;
   logic                    m_ready_i;
   logic [T_DATA_RATIO-1:0] m_keep_o;
   logic                    m_last_o;

   modport master (
      input  s_valid_i, s_last_i, m_ready_i,
      output s_ready_o, lane_we_o, m_valid_o, m_keep_o, m_last_o
   );

   modport slave (
      output s_valid_i, s_last_i, m_ready_i,
      input  s_ready_o, lane_we_o, m_valid_o, m_keep_o, m_last_o
   );
endinterface

// File: rtl/stream_upsize_ctrl.sv
// Narrow-to-wide stream upsizer sequencer: steers beats into external lane registers
// and presents the wide word. Define STREAM_UPSIZE_CTRL_FLUSH_EN to flush idle partial words.
module stream_upsize_ctrl #(
   parameter int unsigned T_DATA_RATIO  = 2,
   parameter int unsigned FLUSH_TIMEOUT = 16
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   stream_upsize_ctrl_if.master bus
);
   localparam int unsigned CW = (T_DATA_RATIO > 2) ? $clog2(T_DATA_RATIO) : 1;

   if (T_DATA_RATIO < 2 || FLUSH_TIMEOUT < 1) begin : g_param_check
      $error("stream_upsize_ctrl: T_DATA_RATIO must be >= 2 and FLUSH_TIMEOUT >= 1");
   end

   typedef enum logic {ACCUM = 1'b0, FULL = 1'b1} state_t;

   state_t                  state_q;
   logic [CW-1:0]           cnt_q;
   logic [T_DATA_RATIO-1:0] keep_q;
   logic                    last_q;
   logic                    acc_c;
   logic                    flush_c;
   logic [CW-1:0]           lane_idx_c;

   // In FULL the draining word frees lane 0 for the next word in the same cycle
   assign bus.s_ready_o = !rst_i && ((state_q == ACCUM) || bus.m_ready_i);
   assign acc_c         = bus.s_valid_i && bus.s_ready_o;
   assign lane_idx_c    = (state_q == FULL) ? '0 : cnt_q;
   assign bus.lane_we_o = acc_c ? (T_DATA_RATIO'(1) << lane_idx_c) : '0;

   assign bus.m_valid_o = (state_q == FULL);
   assign bus.m_keep_o  = keep_q;
   assign bus.m_last_o  = last_q;

`ifdef STREAM_UPSIZE_CTRL_FLUSH_EN
   localparam int unsigned IW = (FLUSH_TIMEOUT > 1) ? $clog2(FLUSH_TIMEOUT) : 1;
   logic [IW-1:0] idle_q;

   // Fires on the idle cycle that would bring the count up to FLUSH_TIMEOUT
   assign flush_c = (state_q == ACCUM) && (cnt_q != '0) && !bus.s_valid_i &&
                    (idle_q == IW'(FLUSH_TIMEOUT - 1));

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idle_q <= '0;
      end else if (acc_c || flush_c || cnt_q == '0 || state_q != ACCUM) begin
         idle_q <= '0;
      end else begin
         idle_q <= idle_q + IW'(1);
      end
   end
`else
   assign flush_c = 1'b0;
`endif

   // Sequencer: lane index, keep mask and packet-end flag
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= ACCUM;
         cnt_q   <= '0;
         keep_q  <= '0;
         last_q  <= 1'b0;
      end else begin
         case (state_q)
            ACCUM: begin
               if (acc_c) begin
                  keep_q[cnt_q] <= 1'b1;
                  if (cnt_q == CW'(T_DATA_RATIO - 1) || bus.s_last_i) begin
                     state_q <= FULL;
                     last_q  <= bus.s_last_i;
                     cnt_q   <= '0;
                  end else begin
                     cnt_q <= cnt_q + CW'(1);
                  end
               end else if (flush_c) begin
                  state_q <= FULL;
                  last_q  <= 1'b0;
                  cnt_q   <= '0;
               end
            end
            FULL: begin
               if (bus.m_ready_i) begin
                  if (!acc_c) begin
                     state_q <= ACCUM;
                     keep_q  <= '0;
                     last_q  <= 1'b0;
                     cnt_q   <= '0;
                  end else if (bus.s_last_i) begin
                     keep_q <= T_DATA_RATIO'(1);
                     last_q <= 1'b1;
                  end else begin
                     state_q <= ACCUM;
                     keep_q  <= T_DATA_RATIO'(1);
                     last_q  <= 1'b0;
                     cnt_q   <= CW'(1);
                  end
               end
            end
            default: state_q <= ACCUM;
         endcase
      end
   end
endmodule

// File: tb/tb_stream_upsize_ctrl.sv
// Scoreboard bench for stream_upsize_ctrl: a beat-counting packet model predicts
// per-cycle handshake/lane behaviour and the sequence of emitted wide words.
module tb_stream_upsize_ctrl;
   localparam int unsigned T  = 4;
   localparam int unsigned TO = 4;

   logic clk = 1'b0;
   logic rst = 1'b1;

   stream_upsize_ctrl_if #(.T_DATA_RATIO(T)) bus ();

   stream_upsize_ctrl #(.T_DATA_RATIO(T), .FLUSH_TIMEOUT(TO)) dut (
      .clk_i (clk),
      .rst_i (rst),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit         ready;
      bit         valid;
      bit [T-1:0] lane;
   } cyc_t;

   typedef struct {
      bit [T-1:0] keep;
      bit         last;
   } word_t;

   cyc_t  q_cyc[$];
   word_t q_word[$];

   int tests = 0;
   int fails = 0;

   // Reference model: beats collected in the open word, and whether a finished word awaits drain
   int cur_n = 0;
   bit pend  = 0;
   int idle  = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic close_word(input bit last);
      word_t w;
      w.keep = T'((1 << cur_n) - 1);
      w.last = last;
      q_word.push_back(w);
      pend  = 1;
      cur_n = 0;
      idle  = 0;
   endtask

   task automatic cycle(input bit sv, input bit sl, input bit mr, input bit rs);
      cyc_t       c;
      bit         acc;
      bit [T-1:0] one;
      one = 1;
      @(posedge clk);
      #1;
      rst           = rs;
      bus.s_valid_i = sv;
      bus.s_last_i  = sl;
      bus.m_ready_i = mr;
      if (rs) begin
         c.ready = 0;
         c.valid = 0;
         c.lane  = '0;
         q_cyc.push_back(c);
         if (pend) void'(q_word.pop_back());
         pend  = 0;
         cur_n = 0;
         idle  = 0;
         return;
      end
      c.valid = pend;
      c.ready = !pend || mr;
      acc     = sv && c.ready;
      c.lane  = acc ? (one << cur_n) : '0;
      q_cyc.push_back(c);
      if (pend && mr) pend = 0;
      if (acc) begin
         cur_n++;
         idle = 0;
         if (cur_n == int'(T) || sl) close_word(sl);
      end else if (cur_n != 0 && !pend) begin
`ifdef STREAM_UPSIZE_CTRL_FLUSH_EN
         idle++;
         if (idle == int'(TO)) close_word(1'b0);
`endif
      end
   endtask

   task automatic beats(input int n, input int last_at, input bit mr);
      for (int i = 0; i < n; i++) cycle(1'b1, (i == last_at), mr, 1'b0);
   endtask

   // Monitor: per-cycle handshake checks, word checks on every wide-side handshake
   initial begin : mon
      cyc_t  c;
      word_t w;
      forever begin
         @(negedge clk);
         if (q_cyc.size() != 0) begin
            c = q_cyc.pop_front();
            chk("s_ready", 32'(bus.s_ready_o), 32'(c.ready));
            chk("m_valid", 32'(bus.m_valid_o), 32'(c.valid));
            chk("lane_we", 32'(bus.lane_we_o), 32'(c.lane));
            if (bus.m_valid_o && bus.m_ready_i && !rst) begin
               if (q_word.size() == 0) begin
                  tests++;
                  fails++;
                  $display("FAIL word_unexpected: got keep=%b last=%b expected no word at %0t",
                           bus.m_keep_o, bus.m_last_o, $time);
               end else begin
                  w = q_word.pop_front();
                  chk("m_keep", 32'(bus.m_keep_o), 32'(w.keep));
                  chk("m_last", 32'(bus.m_last_o), 32'(w.last));
               end
            end
         end
      end
   end

   initial begin : drv
      bus.s_valid_i = 1'b0;
      bus.s_last_i  = 1'b0;
      bus.m_ready_i = 1'b0;
      for (int i = 0; i < 3; i++) cycle(1'b1, 1'b0, 1'b1, 1'b1);

      // Full word closed by last
      beats(4, 3, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      // Short packet, next beat lands in the drain cycle
      beats(2, 1, 1'b1);
      beats(3, 2, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      // Sustained 12-beat packet
      beats(12, 11, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      // Backpressure on a full word
      beats(4, 3, 1'b1);
      for (int i = 0; i < 5; i++) cycle(1'b1, 1'b0, 1'b0, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      // Reset mid-word
      beats(3, -1, 1'b1);
      cycle(1'b1, 1'b0, 1'b1, 1'b1);
      beats(2, 1, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);
      // Idle partial word
      beats(3, -1, 1'b1);
      for (int i = 0; i < 6; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);
      beats(1, 0, 1'b1);
      cycle(1'b0, 1'b0, 1'b1, 1'b0);

      // Randomized traffic, dense then sparse
      for (int i = 0; i < 3000; i++) begin
         bit sv, sl, mr, rs;
         sv = (i < 1500) ? ($urandom_range(0, 9) < 7) : ($urandom_range(0, 9) < 4);
         sl = ($urandom_range(0, 4) == 0);
         mr = ($urandom_range(0, 9) < 7);
         rs = ($urandom_range(0, 199) == 0);
         cycle(sv, sl, mr, rs);
      end
      for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 1'b1, 1'b0);

      @(negedge clk);
      #1;
      chk("words_outstanding", 32'(q_word.size()), 32'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule

// File: doc/stream_upsize_ctrl.md
Name: stream_upsize_ctrl

Overview:
- Sequencing controller for the narrow-to-wide stream upsizer datapath.
- Accepts narrow beats and steers each one into a lane of the wide word through one-hot lane write enables.
- Tracks the lane index and keep mask, and presents the completed wide word on the master side with valid/ready/last/keep.
- Owns no data storage: the lane registers are external and use lane_we_o as write enable, fed from s_data.

Parameters:
- T_DATA_RATIO, 2, number of narrow lanes per wide word; legal range >= 2.
- FLUSH_TIMEOUT, 16, idle cycles before a partial word is flushed; used only with the optional feature; legal range >= 1.

Ports:
- clk_i  input  1  clock, all state on the rising edge.
- rst_i  input  1  reset, asynchronous, active-high.
- s_valid_i  input  1  narrow beat valid.
- s_last_i  input  1  narrow beat is the last beat of its packet.
- s_ready_o  output  1  controller accepts a narrow beat.
- lane_we_o  output  T_DATA_RATIO  one-hot lane write enable; all-zero when no beat is accepted.
- m_valid_o  output  1  wide word valid.
- m_ready_i  input  1  downstream accepts the wide word.
- m_keep_o  output  T_DATA_RATIO  lanes holding valid data; bit i = lane i.
- m_last_o  output  1  wide word closes a packet.

Behaviour:
- State registers:
  - state_q: ACCUM or FULL.
  - cnt_q: lane index, width max(1, $clog2(T_DATA_RATIO)).
  - keep_q: T_DATA_RATIO bits.
  - last_q: 1 bit.
- Reset (async assert, sync deassert):
  - state_q=ACCUM, cnt_q=0, keep_q=0, last_q=0.
  - m_valid_o=0, s_ready_o=0 and lane_we_o=0 while rst_i=1.
  - Reset mid-word discards the partial word; no output is produced for it.
- Beat acceptance: acc = s_valid_i && s_ready_o. lane_we_o = acc ? (1 << idx) : 0, where idx=cnt_q in ACCUM and idx=0 in FULL.
- Outputs: m_valid_o = (state_q==FULL); m_keep_o = keep_q; m_last_o = last_q. Outputs are stable while m_valid_o=1 and m_ready_i=0.
- ACCUM: s_ready_o=1.
  - On acc: keep_q[cnt_q] <= 1.
  - If cnt_q==T_DATA_RATIO-1 or s_last_i: go to FULL, last_q <= s_last_i, cnt_q <= 0.
  - Otherwise: cnt_q <= cnt_q+1.
- FULL: s_ready_o = m_ready_i (the word drains and the next word's lane 0 is written in the same cycle). Lane 0 is read combinationally before the write lands, so there is no hazard.
  - m_ready_i=0: hold all state.
  - m_ready_i=1, no acc: go to ACCUM, keep_q <= 0, last_q <= 0, cnt_q <= 0.
  - m_ready_i=1, acc with s_last_i=1: stay FULL, keep_q <= 1 (lane 0 only), last_q <= 1.
  - m_ready_i=1, acc with s_last_i=0: go to ACCUM, keep_q <= 1 (lane 0 only), last_q <= 0, cnt_q <= 1.
- Latency: the wide word is valid the cycle after its final lane or last beat is accepted.
- Throughput: back-to-back, one narrow beat per cycle sustained while m_ready_i=1. No bubble at the word boundary.
- Keep mask is always contiguous from bit 0. A full word has keep all-ones.
- A packet of length k*T_DATA_RATIO ends on a full word with m_last_o=1. No empty trailing word is ever emitted.
- s_valid_i=0 in ACCUM: hold. No timeout without the optional feature.

Optional Feature:
- Macro: STREAM_UPSIZE_CTRL_FLUSH_EN.
- Defined:
  - Adds an idle counter, cleared on every acc and whenever cnt_q==0.
  - In ACCUM with cnt_q!=0, it increments each cycle s_valid_i=0.
  - When it reaches FLUSH_TIMEOUT, the controller goes to FULL with the current keep_q, last_q=0, cnt_q=0.
  - A beat arriving in that same cycle takes priority: acc is processed normally and the counter clears.
- Undefined: no counter; partial words wait indefinitely for more beats or s_last_i.

Test Plan (T_DATA_RATIO=4, FLUSH_TIMEOUT=4):
- 4 beats, s_last on beat 3, m_ready=1 -> lane_we 0001,0010,0100,1000; next cycle m_valid=1, keep=1111, last=1.
- 2 beats, s_last on beat 1 -> m_valid=1, keep=0011, last=1. A new beat in the drain cycle gets lane_we=0001, and keep becomes 0001.
- Continuous 12 beats, m_ready=1, s_last on beat 11 -> 3 words keep=1111, last only on the third, s_ready never low.
- Full word with m_ready=0 for 5 cycles -> m_valid, keep and last held, s_ready=0, lane_we=0; m_ready=1 releases it once.
- rst_i pulsed after 3 beats -> s_ready=0 during reset; after release cnt=0, keep=0, and the next beat writes lane 0.
- With STREAM_UPSIZE_CTRL_FLUSH_EN: 3 beats then 4 idle cycles -> m_valid=1, keep=0111, last=0. Without the macro: no output.
